// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter width for an l-bit word; never narrower than one bit.
  function automatic int cnt_width(input int l);
    return (l > 1) ? $clog2(l) : 1;
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: captures an L-bit word on qstrobe and emits it one bit per clk.
// Bit order is MSB first by default; define SERIALIZER_LSB_FIRST_EN for LSB first.
//
// state | meaning
// IDLE  | no word in flight, qbit=0, qbiten=0
// SHIFT | emitting captured word, qbiten=1, cnt = index of bit on qbit
module serializer
  import serializer_pkg::*;
#(
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [L-1:0] q,
  input  logic         qstrobe,
  output logic         qbit,
  output logic         qbiten
);

  localparam int            CW   = cnt_width(L);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [L-1:0]  sh, sh_nx;
  logic          last;
  logic          load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sh    <= sh_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    last     = (state == SHIFT) && (cnt == LAST);
    load     = qstrobe && ((state == IDLE) || last);

    if (load) begin
      state_nx = SHIFT;
      cnt_nx   = '0;
      sh_nx    = q;
    end else if (state == SHIFT) begin
      if (last) begin
        // Clearing the shifter forces qbit low once the word is done.
        state_nx = IDLE;
        cnt_nx   = '0;
        sh_nx    = '0;
      end else begin
        cnt_nx = cnt + CW'(1);
`ifdef SERIALIZER_LSB_FIRST_EN
        sh_nx  = {1'b0, sh[L-1:1]};
`else
        sh_nx  = {sh[L-2:0], 1'b0};
`endif
      end
    end
  end

`ifdef SERIALIZER_LSB_FIRST_EN
  assign qbit = sh[0];
`else
  assign qbit = sh[L-1];
`endif

  assign qbiten = (state == SHIFT);

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer (L=8): reset, single/repeat words, ignored mid-word strobe,
// back-to-back chaining, held strobe and asynchronous reset mid-word.
module tb_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] q;
  logic       qstrobe;
  logic       qbit;
  logic       qbiten;

  int n_chk = 0;
  int n_bad = 0;

  serializer #(.L(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .q       (q),
    .qstrobe (qstrobe),
    .qbit    (qbit),
    .qbiten  (qbiten)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bit n (0 = first emitted) of word w in the order this build emits.
  function automatic logic exp_bit(input logic [7:0] w, input int n);
`ifdef SERIALIZER_LSB_FIRST_EN
    return w[n];
`else
    return w[7-n];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] w);
    q       = w;
    qstrobe = 1'b1;
    tick();
    qstrobe = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"},  qbiten, 1'b0);
    check({tag, "_bit"}, qbit,   1'b0);
  endtask

  task automatic expect_word(input string tag, input logic [7:0] w);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("%s_en%0d", tag, n),  qbiten, 1'b1);
      check($sformatf("%s_bit%0d", tag, n), qbit,   exp_bit(w, n));
      tick();
    end
    check_idle({tag, "_end"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq16;
    reset   = 1'b0;
    q       = 8'hFF;
    qstrobe = 1'b0;

    // reset held with strobe toggling
    for (int i = 0; i < 4; i++) begin
      qstrobe = ~qstrobe;
      @(negedge clk);
      check_idle($sformatf("rst%0d", i));
    end
    tick();
    reset   = 1'b1;
    qstrobe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("post_rst%0d", i));
    end

    // single word 01101001 -> 0,1,1,0,1,0,0,1 (MSB first)
    strobe(8'b0110_1001);
    q = 8'h00;
    expect_word("single", 8'b0110_1001);
    tick();
    check_idle("gap");

    // repeat load, 10 cycles after the first strobe
    strobe(8'b0110_1001);
    expect_word("repeat", 8'b0110_1001);

    // strobe at bit 3 is ignored
    strobe(8'hA5);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("mid_en%0d", n),  qbiten, 1'b1);
      check($sformatf("mid_bit%0d", n), qbit,   exp_bit(8'hA5, n));
      if (n == 3) begin
        q       = 8'hFF;
        qstrobe = 1'b1;
      end
      tick();
      qstrobe = 1'b0;
    end
    check_idle("mid_end");
    tick();

    // back-to-back: F0 then 0F on final bit, 16 contiguous bits
    strobe(8'hF0);
    for (int n = 0; n < 16; n++) begin
      seq16 = (n < 8) ? 8'hF0 : 8'h0F;
      check($sformatf("b2b_en%0d", n),  qbiten, 1'b1);
      check($sformatf("b2b_bit%0d", n), qbit,   exp_bit(seq16, n % 8));
      if (n == 7) begin
        q       = 8'h0F;
        qstrobe = 1'b1;
      end
      tick();
      qstrobe = 1'b0;
    end
    check_idle("b2b_end");
    tick();

    // strobe held three cycles in IDLE counts once; q changes afterwards ignored
    q       = 8'hC3;
    qstrobe = 1'b1;
    tick();
    q = 8'h00;
    for (int n = 0; n < 8; n++) begin
      check($sformatf("hold_en%0d", n),  qbiten, 1'b1);
      check($sformatf("hold_bit%0d", n), qbit,   exp_bit(8'hC3, n));
      if (n == 2) qstrobe = 1'b0;
      tick();
    end
    check_idle("hold_end");
    tick();

    // asynchronous reset at bit 4 of 8'h69
    strobe(8'h69);
    for (int n = 0; n < 4; n++) tick();
    check("rst_mid_pre_en",  qbiten, 1'b1);
    check("rst_mid_pre_bit", qbit,   exp_bit(8'h69, 4));
    #2 reset = 1'b0;
    #1 check_idle("rst_mid_async");
    tick();
    check_idle("rst_mid_held");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle($sformatf("rst_mid_after%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
